// File: rtl/mat_job_ctrl_if.sv
// Byte-stream, transmitter and multiplier signals of mat_job_ctrl grouped as one bundle.
// master = the controller, slave = the UART/multiplier side.
interface mat_job_ctrl_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic [31:0] a_flat;
  logic [31:0] b_flat;
  logic [31:0] c_flat;
  logic        mm_start;
  logic        done;
  logic        err;

  modport master (
    input  rx_byte, rx_valid, tx_busy, c_flat,
    output tx_byte, tx_start, a_flat, b_flat, mm_start, done, err
  );

  modport slave (
    output rx_byte, rx_valid, tx_busy, c_flat,
    input  tx_byte, tx_start, a_flat, b_flat, mm_start, done, err
  );
endinterface

// File: rtl/mat_job_ctrl.sv
// 2x2 matrix job controller: parses FF/sel/job/4-element packets, launches the multiplier, replies FF,job,c11..c22.
// Reply bytes wait on tx_busy; define MAT_JOB_CHECKSUM_EN for a trailing XOR byte in both directions.
module mat_job_ctrl #(
  parameter int MM_LATENCY = 2,
  parameter int RX_TIMEOUT = 1200000
) (
  input logic            clk,
  input logic            rst,
  mat_job_ctrl_if.master bus
);
  localparam int              TMO_W   = $clog2(RX_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(RX_TIMEOUT);
  localparam logic [3:0]      LAT     = 4'(MM_LATENCY);
`ifdef MAT_JOB_CHECKSUM_EN
  localparam logic [2:0]      TX_LAST = 3'd6;
`else
  localparam logic [2:0]      TX_LAST = 3'd5;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_JOB, S_LOAD, S_MUL_WAIT, S_TX} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [7:0]        job_id_q, job_id_d;
  logic              a_valid_q, a_valid_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       stage_q, stage_d;
  logic [3:0]        lat_q, lat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       c_q, c_d;
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              mm_start_q, mm_start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       a_flat_q, a_flat_d;
  logic [31:0]       b_flat_q, b_flat_d;
`ifdef MAT_JOB_CHECKSUM_EN
  logic [7:0]        xsum_q, xsum_d;
  logic              chk_pend_q, chk_pend_d;
`endif

  logic        rx_wait, timeout, job_ok, lat_hit, tx_acc;
  logic        load_data, load_end, load_ok;
  logic [31:0] stage_wr, commit_val;
  logic [7:0]  tx_mux;

  assign rx_wait = (state_q == S_SEL) || (state_q == S_JOB) || (state_q == S_LOAD);
  assign timeout = rx_wait && !bus.rx_valid && (tmo_q == TMO_MAX);
  assign job_ok  = !sel_q || ((bus.rx_byte == job_id_q) && a_valid_q);
  assign lat_hit = (lat_q == LAT);
  assign tx_acc  = tx_start_q && !bus.tx_busy;

  always_comb begin
    stage_wr = stage_q;
    case (idx_q)
      2'd0:    stage_wr[31:24] = bus.rx_byte;
      2'd1:    stage_wr[23:16] = bus.rx_byte;
      2'd2:    stage_wr[15:8]  = bus.rx_byte;
      default: stage_wr[7:0]   = bus.rx_byte;
    endcase
  end

  // Elements are staged and only committed once the packet is known good.
`ifdef MAT_JOB_CHECKSUM_EN
  assign load_data  = bus.rx_valid && !chk_pend_q;
  assign load_end   = bus.rx_valid && chk_pend_q;
  assign load_ok    = (bus.rx_byte == xsum_q);
  assign commit_val = stage_q;
`else
  assign load_data  = bus.rx_valid;
  assign load_end   = bus.rx_valid && (idx_q == 2'd3);
  assign load_ok    = 1'b1;
  assign commit_val = stage_wr;
`endif

  always_comb begin
    case (tx_idx_q)
      3'd0:    tx_mux = 8'hFF;
      3'd1:    tx_mux = job_id_q;
      3'd2:    tx_mux = c_q[31:24];
      3'd3:    tx_mux = c_q[23:16];
      3'd4:    tx_mux = c_q[15:8];
      3'd5:    tx_mux = c_q[7:0];
`ifdef MAT_JOB_CHECKSUM_EN
      3'd6:    tx_mux = job_id_q ^ c_q[31:24] ^ c_q[23:16] ^ c_q[15:8] ^ c_q[7:0];
`endif
      default: tx_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.rx_valid && (bus.rx_byte == 8'hFF)) state_d = S_SEL;
      S_SEL: begin
        if (timeout)           state_d = S_IDLE;
        else if (bus.rx_valid) state_d = (bus.rx_byte[7:1] == 7'd0) ? S_JOB : S_IDLE;
      end
      S_JOB: begin
        if (timeout)           state_d = S_IDLE;
        else if (bus.rx_valid) state_d = job_ok ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        if (timeout)       state_d = S_IDLE;
        else if (load_end) state_d = (load_ok && sel_q) ? S_MUL_WAIT : S_IDLE;
      end
      S_MUL_WAIT: if (lat_hit) state_d = S_TX;
      S_TX:       if (tx_acc && (tx_idx_q == TX_LAST)) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_d      = sel_q;
    job_id_d   = job_id_q;
    a_valid_d  = a_valid_q;
    idx_d      = idx_q;
    stage_d    = stage_q;
    lat_d      = lat_q;
    c_d        = c_q;
    tx_idx_d   = tx_idx_q;
    tx_start_d = tx_start_q;
    tx_byte_d  = tx_byte_q;
    a_flat_d   = a_flat_q;
    b_flat_d   = b_flat_q;
    mm_start_d = 1'b0;
    done_d     = 1'b0;
    err_d      = timeout;
`ifdef MAT_JOB_CHECKSUM_EN
    xsum_d     = xsum_q;
    chk_pend_d = chk_pend_q;
`endif
    tmo_d = '0;
    if (rx_wait && !bus.rx_valid) tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

    case (state_q)
      S_SEL: if (bus.rx_valid) begin
        if (bus.rx_byte[7:1] == 7'd0) begin
          sel_d = bus.rx_byte[0];
`ifdef MAT_JOB_CHECKSUM_EN
          xsum_d = bus.rx_byte;
`endif
        end else begin
          err_d = 1'b1;
        end
      end
      S_JOB: if (bus.rx_valid) begin
        idx_d = 2'd0;
`ifdef MAT_JOB_CHECKSUM_EN
        xsum_d     = xsum_q ^ bus.rx_byte;
        chk_pend_d = 1'b0;
`endif
        if (!sel_q) begin
          job_id_d  = bus.rx_byte;
          a_valid_d = 1'b0;
        end else if (!job_ok) begin
          err_d     = 1'b1;
          a_valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_data) begin
          stage_d = stage_wr;
          idx_d   = idx_q + 2'd1;
`ifdef MAT_JOB_CHECKSUM_EN
          xsum_d = xsum_q ^ bus.rx_byte;
          if (idx_q == 2'd3) chk_pend_d = 1'b1;
`endif
        end
        if (load_end) begin
          if (!load_ok) begin
            err_d = 1'b1;
          end else if (!sel_q) begin
            a_flat_d  = commit_val;
            a_valid_d = 1'b1;
          end else begin
            b_flat_d   = commit_val;
            mm_start_d = 1'b1;
            lat_d      = 4'd0;
          end
        end
      end
      S_MUL_WAIT: begin
        if (lat_hit) begin
          c_d        = bus.c_flat;
          a_valid_d  = 1'b0;
          tx_idx_d   = 3'd0;
          tx_start_d = 1'b0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_TX: begin
        // Drop tx_start for one cycle after each accepted byte before presenting the next.
        if (tx_acc) begin
          tx_start_d = 1'b0;
          tx_idx_d   = tx_idx_q + 3'd1;
          if (tx_idx_q == TX_LAST) done_d = 1'b1;
        end else if (!tx_start_q) begin
          tx_start_d = 1'b1;
          tx_byte_d  = tx_mux;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= 1'b0;
      job_id_q   <= 8'h00;
      a_valid_q  <= 1'b0;
      idx_q      <= 2'd0;
      stage_q    <= '0;
      lat_q      <= 4'd0;
      tmo_q      <= '0;
      c_q        <= '0;
      tx_idx_q   <= 3'd0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      a_flat_q   <= '0;
      b_flat_q   <= '0;
`ifdef MAT_JOB_CHECKSUM_EN
      xsum_q     <= 8'h00;
      chk_pend_q <= 1'b0;
`endif
    end else begin
      sel_q      <= sel_d;
      job_id_q   <= job_id_d;
      a_valid_q  <= a_valid_d;
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      lat_q      <= lat_d;
      tmo_q      <= tmo_d;
      c_q        <= c_d;
      tx_idx_q   <= tx_idx_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      mm_start_q <= mm_start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      a_flat_q   <= a_flat_d;
      b_flat_q   <= b_flat_d;
`ifdef MAT_JOB_CHECKSUM_EN
      xsum_q     <= xsum_d;
      chk_pend_q <= chk_pend_d;
`endif
    end
  end

  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_start = tx_start_q;
  assign bus.mm_start = mm_start_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.a_flat   = a_flat_q;
  assign bus.b_flat   = b_flat_q;
endmodule

// File: tb/tb_mat_job_ctrl.sv
// Directed bench for mat_job_ctrl: packet flow, job mismatch, tx backpressure, rx timeout, mid-reply reset.
// The multiplier is modelled as a delay line that shows the product only in the cycle it is due.
module tb_mat_job_ctrl;
  localparam int MM_LAT = 3;
  localparam int RX_TMO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mat_job_ctrl_if bus();

  mat_job_ctrl #(.MM_LATENCY(MM_LAT), .RX_TIMEOUT(RX_TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0, mm_cnt = 0, done_cnt = 0, tx_viol = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] exp_c = '0;
  logic [31:0] a_at_mm = '0, b_at_mm = '0, a_at_cap = '0, b_at_cap = '0;
  logic [7:0]  mm_sr = '0;
  logic        hold_q = 1'b0, acc_q = 1'b0;
  logic [7:0]  held_byte = '0;

  assign bus.c_flat = mm_sr[MM_LAT-1] ? exp_c : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    mm_sr <= {mm_sr[6:0], bus.mm_start};
    if (bus.err) err_cnt <= err_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.mm_start) begin
      mm_cnt  <= mm_cnt + 1;
      a_at_mm <= bus.a_flat;
      b_at_mm <= bus.b_flat;
    end
    if (mm_sr[MM_LAT-1]) begin
      a_at_cap <= bus.a_flat;
      b_at_cap <= bus.b_flat;
    end
    if (bus.tx_start && !bus.tx_busy) tx_q.push_back(bus.tx_byte);
    if ((hold_q && (!bus.tx_start || bus.tx_byte != held_byte)) || (acc_q && bus.tx_start))
      tx_viol <= tx_viol + 1;
    hold_q    <= bus.tx_start && bus.tx_busy;
    acc_q     <= bus.tx_start && !bus.tx_busy;
    held_byte <= bus.tx_byte;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] a11, a12, a21, a22, b11, b12, b21, b22;
    {a11, a12, a21, a22} = a;
    {b11, b12, b21, b22} = b;
    return {8'(a11 * b11 + a12 * b21), 8'(a11 * b12 + a12 * b22),
            8'(a21 * b11 + a22 * b21), 8'(a21 * b12 + a22 * b22)};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] sel, input logic [7:0] job, input logic [31:0] el);
    send(8'hFF); send(sel); send(job);
    send(el[31:24]); send(el[23:16]); send(el[15:8]); send(el[7:0]);
`ifdef MAT_JOB_CHECKSUM_EN
    send(sel ^ job ^ el[31:24] ^ el[23:16] ^ el[15:8] ^ el[7:0]);
`endif
  endtask

  task automatic wait_done(input string tag);
    int start;
    start = done_cnt;
    for (int i = 0; i < 400 && done_cnt == start; i++) @(posedge clk);
    #1;
    chk(tag, done_cnt, start + 1);
  endtask

  task automatic check_reply(input string tag, input logic [7:0] job, input logic [31:0] c);
    logic [7:0]  e[$];
    logic [31:0] v;
    e.push_back(8'hFF); e.push_back(job);
    e.push_back(c[31:24]); e.push_back(c[23:16]); e.push_back(c[15:8]); e.push_back(c[7:0]);
`ifdef MAT_JOB_CHECKSUM_EN
    e.push_back(job ^ c[31:24] ^ c[23:16] ^ c[15:8] ^ c[7:0]);
`endif
    chk({tag, "_len"}, tx_q.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < tx_q.size()) v = 32'(tx_q[i]);
      else v = 'x;
      chk($sformatf("%s_b%0d", tag, i), v, 32'(e[i]));
    end
    tx_q.delete();
  endtask

  task automatic run_pair(input string tag, input logic [7:0] job, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c_lit);
    int mm0;
    mm0   = mm_cnt;
    exp_c = matmul(a, b);
    send_pkt(8'h00, job, a);
    send_pkt(8'h01, job, b);
    wait_done({tag, "_done"});
    chk({tag, "_mm_once"}, mm_cnt, mm0 + 1);
    chk({tag, "_a_at_mm"}, a_at_mm, a);
    chk({tag, "_b_at_mm"}, b_at_mm, b);
    chk({tag, "_a_at_cap"}, a_at_cap, a);
    chk({tag, "_b_at_cap"}, b_at_cap, b);
    check_reply(tag, job, c_lit);
  endtask

  initial begin
    int e0, m0, d0;
    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_mm_start", bus.mm_start, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_a_flat", bus.a_flat, 0);
    chk("rst_b_flat", bus.b_flat, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic A+B job with hand-computed product
    send(8'h12);
    exp_c = matmul(32'h01020304, 32'h05060708);
    send_pkt(8'h00, 8'h07, 32'h01020304);
    #1;
    chk("a_load", bus.a_flat, 32'h01020304);
    chk("a_no_mm", mm_cnt, 0);
    send_pkt(8'h01, 8'h07, 32'h05060708);
    wait_done("r038_done");
    chk("r038_mm_once", mm_cnt, 1);
    chk("r038_b_at_mm", b_at_mm, 32'h05060708);
    chk("r038_a_at_cap", a_at_cap, 32'h01020304);
    check_reply("r038", 8'h07, 32'h13162B32);
    chk("r038_no_err", err_cnt, 0);

    // Job mismatch, then re-sent B with a_valid cleared, then bad sel byte
    send_pkt(8'h00, 8'h07, 32'h01020304);
    send_pkt(8'h01, 8'h09, 32'h05060708);
    repeat (4) @(negedge clk);
    chk("job_mis_err", err_cnt, 1);
    send_pkt(8'h01, 8'h07, 32'h05060708);
    repeat (4) @(negedge clk);
    chk("job_resend_err", err_cnt, 2);
    chk("job_no_mm", mm_cnt, 1);
    send(8'hFF); send(8'h05);
    repeat (2) @(negedge clk);
    chk("bad_sel_err", err_cnt, 3);
    chk("bad_sel_no_tx", tx_q.size(), 0);

    // Transmitter held busy; stray rx bytes during MUL_WAIT/TX; 0xFF as element data
    bus.tx_busy = 1'b1;
    exp_c = matmul(32'hFF100280, 32'h03FF0401);
    send_pkt(8'h00, 8'h21, 32'hFF100280);
    send_pkt(8'h01, 8'h21, 32'h03FF0401);
    send(8'hFF); send(8'h00); send(8'h05);
    repeat (50) @(negedge clk);
    chk("busy_tx_start", bus.tx_start, 1);
    chk("busy_tx_byte", bus.tx_byte, 32'hFF);
    chk("busy_no_accept", tx_q.size(), 0);
    bus.tx_busy = 1'b0;
    wait_done("r040_done");
    check_reply("r040", 8'h21, 32'h3D11067E);
    chk("r040_no_err", err_cnt, 3);
    chk("tx_handshake", tx_viol, 0);

    // Rx timeout after three A element bytes
    send(8'hFF); send(8'h00); send(8'h30); send(8'h11); send(8'h22); send(8'h33);
    repeat (RX_TMO) @(posedge clk);
    #1;
    chk("tmo_not_yet", bus.err, 0);
    @(posedge clk);
    #1;
    chk("tmo_err", bus.err, 1);
    @(posedge clk);
    #1;
    chk("tmo_pulse", bus.err, 0);
    run_pair("r041", 8'h42, 32'h02000003, 32'h0A0B0C0D, 32'h14162427);
    chk("r041_err_total", err_cnt, 4);

    // Reset while the third reply byte is presented
    exp_c = matmul(32'h01010101, 32'h01020304);
    send_pkt(8'h00, 8'h55, 32'h01010101);
    send_pkt(8'h01, 8'h55, 32'h01020304);
    for (int i = 0; i < 200 && !(tx_q.size() == 2 && bus.tx_start); i++) @(negedge clk);
    chk("rst_reach_b3", tx_q.size(), 2);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_start", bus.tx_start, 0);
    chk("arst_tx_byte", bus.tx_byte, 0);
    chk("arst_a_flat", bus.a_flat, 0);
    chk("arst_b_flat", bus.b_flat, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_err", bus.err, 0);
    chk("arst_mm", bus.mm_start, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_done", done_cnt, d0);
    chk("arst_no_more_tx", tx_q.size(), 2);
    tx_q.delete();
    e0 = err_cnt;
    send_pkt(8'h01, 8'h55, 32'h01020304);
    repeat (3) @(negedge clk);
    chk("arst_avalid_clr", err_cnt, e0 + 1);
    run_pair("r042", 8'h66, 32'h01010101, 32'h01020304, 32'h04060406);

`ifdef MAT_JOB_CHECKSUM_EN
    // Bad checksum on A leaves a_flat untouched and a_valid clear
    e0 = err_cnt;
    m0 = mm_cnt;
    send(8'hFF); send(8'h00); send(8'h77);
    send(8'h09); send(8'h09); send(8'h09); send(8'h09);
    send(8'h00 ^ 8'h77 ^ 8'hA5);
    #1;
    chk("cks_bad_err", err_cnt, e0 + 1);
    chk("cks_no_update", bus.a_flat, 32'h01010101);
    send_pkt(8'h01, 8'h77, 32'h01020304);
    repeat (3) @(negedge clk);
    chk("cks_avalid_clr", err_cnt, e0 + 2);
    chk("cks_no_mm", mm_cnt, m0);
    run_pair("r043", 8'h78, 32'h01020304, 32'h05060708, 32'h13162B32);
`else
    m0 = mm_cnt;
    chk("final_mm_total", m0, 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
